// File: rtl/csa14_pkg.sv
// csa14_pkg: shared constants, state encoding and sizing helper for the multiword adder
package csa14_pkg;
  localparam int WORD_W = 14;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/SQRT_CSA14bit.sv
// SQRT_CSA14bit: 14-bit square-root carry-select adder, blocks of 2,2,3,3,4 bits
module SQRT_CSA14bit (
  input  logic [13:0] a,
  input  logic [13:0] b,
  input  logic        cin,
  output logic [13:0] sumtot,
  output logic        cout
);
  localparam int B_LO [5] = '{0, 2, 4, 7, 10};
  localparam int B_W  [5] = '{2, 2, 3, 3, 4};
  logic [5:0] w_c;
  assign w_c[0] = cin;
  for (genvar k = 0; k < 5; k++) begin : g_blk
    logic [B_W[k]:0] w_s0, w_s1;
    assign w_s0 = {1'b0, a[B_LO[k] +: B_W[k]]} + {1'b0, b[B_LO[k] +: B_W[k]]};
    assign w_s1 = w_s0 + {{B_W[k]{1'b0}}, 1'b1};
    assign sumtot[B_LO[k] +: B_W[k]] = w_c[k] ? w_s1[B_W[k]-1:0] : w_s0[B_W[k]-1:0];
    assign w_c[k+1] = w_c[k] ? w_s1[B_W[k]] : w_s0[B_W[k]];
  end
  assign cout = w_c[5];
endmodule

// File: rtl/csa14_multiword_add_seq.sv
// csa14_multiword_add_seq: WORDS*14-bit add done LSW first on one 14-bit carry-select adder
module csa14_multiword_add_seq
  import csa14_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORD_W*WORDS-1:0]   a,
  input  logic [WORD_W*WORDS-1:0]   b,
  input  logic                      cin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_W*WORDS-1:0]   sum,
  output logic                      cout,
  output logic                      overflow
);
  localparam int W  = WORD_W * WORDS;
  localparam int IW = clog2(WORDS);
  state_t r_state, w_next;
  logic [W-1:0] r_a, r_b, r_sum;
  logic [IW-1:0] r_idx;
  logic r_carry, r_a_msb, r_b_msb, r_cout, r_ovf;
  logic [WORD_W-1:0] w_sum;
  logic w_cout, w_last;
  SQRT_CSA14bit u_add (
    .a      (r_a[WORD_W-1:0]),
    .b      (r_b[WORD_W-1:0]),
    .cin    (r_carry),
    .sumtot (w_sum),
    .cout   (w_cout)
  );
  assign w_last = r_idx == IW'(WORDS - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = (r_state == ST_IDLE && in_valid)  ? ST_RUN  :
             (r_state == ST_RUN  && w_last)    ? ST_DONE :
             (r_state == ST_DONE && out_ready) ? ST_IDLE : r_state;
  end
  always_comb begin
    in_ready  = r_state == ST_IDLE;
    out_valid = r_state == ST_DONE;
  end
  // Finished words enter at the top of r_sum so word 0 lands at the bottom after WORDS shifts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == ST_IDLE && in_valid) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_a_msb <= a[W-1];
      r_b_msb <= b[W-1];
      r_idx   <= '0;
    end else if (r_state == ST_RUN) begin
      r_sum   <= {w_sum, r_sum[W-1:WORD_W]};
      r_carry <= w_cout;
      r_a     <= r_a >> WORD_W;
      r_b     <= r_b >> WORD_W;
      r_idx   <= r_idx + 1'b1;
      if (w_last) begin
        r_cout <= w_cout;
        r_ovf  <= (r_a_msb == r_b_msb) && (w_sum[WORD_W-1] != r_a_msb);
      end
    end
  end
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;
endmodule

// File: tb/tb_csa14_multiword_add_seq.sv
// tb_csa14_multiword_add_seq: directed checks of the sequential 56-bit adder (WORDS=4)
module tb_csa14_multiword_add_seq;
  localparam int W = 56;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, overflow;
  logic [W-1:0] a, b, sum;
  int errors = 0;
  int checks = 0;

  csa14_multiword_add_seq #(.WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Presents one operand set from IDLE, then reports edges until out_valid (-1 if never).
  task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, output int lat);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = '1; b = '1; cin = 1'b1;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = n; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if ({sum, cout, overflow} !== '0) begin errors++; $display("FAIL reset_outputs sum=%h cout=%b ovf=%b exp=0", sum, cout, overflow); end
  endtask

  task automatic test_carry();
    int lat;
    run_add(56'h3A14, 56'h32BF, 1'b0, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL carry_latency got=%0d exp=4", lat); end
    checks++; if (sum !== 56'h00000000006CD3) begin errors++; $display("FAIL carry_sum got=%h exp=6cd3", sum); end
    checks++; if (cout !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL carry_flags cout=%b ovf=%b exp=0,0", cout, overflow); end
    @(posedge clk); #1;
  endtask

  task automatic test_ripple();
    int lat;
    run_add(56'hFFFFFFFFFFFFFF, 56'h0, 1'b1, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL ripple_latency got=%0d exp=4", lat); end
    checks++; if (sum !== 56'h0) begin errors++; $display("FAIL ripple_sum got=%h exp=0", sum); end
    checks++; if (cout !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL ripple_flags cout=%b ovf=%b exp=1,0", cout, overflow); end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    int lat;
    run_add(56'h7FFFFFFFFFFFFF, 56'h00000000000001, 1'b0, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL ovf_pos_latency got=%0d exp=4", lat); end
    checks++; if (sum !== 56'h80000000000000) begin errors++; $display("FAIL ovf_pos_sum got=%h exp=80000000000000", sum); end
    checks++; if (cout !== 1'b0 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_pos_flags cout=%b ovf=%b exp=0,1", cout, overflow); end
    @(posedge clk); #1;
    run_add(56'h80000000000000, 56'h80000000000000, 1'b0, lat);
    checks++; if (sum !== 56'h0) begin errors++; $display("FAIL ovf_neg_sum got=%h exp=0", sum); end
    checks++; if (cout !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_neg_flags cout=%b ovf=%b exp=1,1", cout, overflow); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    run_add(56'h1234, 56'h0001, 1'b0, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL bp_latency got=%0d exp=4", lat); end
    a = 56'h0ABC; b = 56'h0111; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 56'h1235 || cout !== 1'b0 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d valid=%b ready=%b sum=%h cout=%b ovf=%b exp=1,0,1235,0,0", i, out_valid, in_ready, sum, cout, overflow);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 56'h1235) begin
      errors++; $display("FAIL bp_release valid=%b ready=%b sum=%h exp=0,1,1235", out_valid, in_ready, sum);
    end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_accept ready=%b exp=0", in_ready); end
    in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = n; break; end
    end
    checks++; if (lat != 4) begin errors++; $display("FAIL bp_next_latency got=%0d exp=4", lat); end
    checks++; if (sum !== 56'h0BCD) begin errors++; $display("FAIL bp_next_sum got=%h exp=bcd", sum); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat;
    a = 56'hFFFFFFFFFFFFFF; b = 56'h1; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 56'h0 || cout !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL rst_mid ready=%b valid=%b sum=%h cout=%b ovf=%b exp=1,0,0,0,0", in_ready, out_valid, sum, cout, overflow);
    end
    repeat (5) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_no_emit valid=%b exp=0", out_valid); end
    end
    run_add(56'h1111, 56'h1111, 1'b0, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL rst_after_latency got=%0d exp=4", lat); end
    checks++; if (sum !== 56'h2222 || cout !== 1'b0) begin errors++; $display("FAIL rst_after_sum sum=%h cout=%b exp=2222,0", sum, cout); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ta, tb;
    logic tc, ev;
    logic [W:0] ref_s;
    int lat;
    out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      ta = {$urandom(), $urandom()};
      tb = {$urandom(), $urandom()};
      tc = 1'($urandom_range(0, 1));
      ref_s = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
      ev = (ta[W-1] == tb[W-1]) && (ref_s[W-1] != ta[W-1]);
      run_add(ta, tb, tc, lat);
      checks++; if (lat != 4) begin errors++; $display("FAIL b2b_latency t=%0d got=%0d exp=4", t, lat); end
      checks++;
      if (sum !== ref_s[W-1:0] || cout !== ref_s[W] || overflow !== ev) begin
        errors++; $display("FAIL b2b_result t=%0d sum=%h cout=%b ovf=%b exp=%h,%b,%b", t, sum, cout, overflow, ref_s[W-1:0], ref_s[W], ev);
      end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse t=%0d valid=%b exp=0", t, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_ripple();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
